iir_fb_sched: RTL
=================

// Module: iir_fb_sched
// PURPOSE
//  Sequencer for the feedback half of the IIR filter. Time-multiplexes one signed
//  multiply-accumulate over ORDER feedback taps per sample:
//    y[n] = x[n] + sum(k=1..ORDER) b_k * y[n-k]
//  Owns the coefficient banks (shadow/active), the output history and the
//  sample handshake. Sits between the feed-forward stage output and the channel datapath.
// PARAMETERS
//  PRECISION   16  sample width, signed two's complement
//  COEF_WIDTH  16  coefficient width, signed
//  COEF_FRAC   14  fractional bits of coefficients (Q2.14 by default)
//  ORDER       4   feedback taps, >=1; AW = max(1,$clog2(ORDER))
// PORTS
//  clk          in   1          clock, all logic rising-edge
//  rst          in   1          synchronous reset, active-high
//  x_valid      in   1          input sample valid
//  x_ready      out  1          block can accept a sample
//  x            in   PRECISION  input sample (feed-forward result)
//  y_valid      out  1          one-cycle pulse, y holds new result
//  y            out  PRECISION  filter output, held until next result
//  busy         out  1          high in any state but IDLE
//  coef_we      in   1          write coef_data into shadow bank[coef_addr]
//  coef_addr    in   AW         tap index 0..ORDER-1 (maps to b_1..b_ORDER); >=ORDER ignored
//  coef_data    in   COEF_WIDTH coefficient value
//  coef_commit  in   1          pulse: copy shadow bank to active bank
//  hist_clr     in   1          pulse: zero y history
// BEHAVIOUR
//  Reset: state=IDLE; x_ready=1, y_valid=0, y=0, busy=0; both banks, history, accumulator, pending flags=0.
//  FSM: IDLE -> MAC (x_valid&x_ready) -> MAC for ORDER cycles (tap k=1..ORDER,
//   acc += b_k*hist[k]) -> DONE (acc_total = (x<<<COEF_FRAC)+acc, arithmetic >>> COEF_FRAC,
//   narrow to PRECISION; register y; shift history, hist[1]=y) -> IDLE.
//  Latency: sample accepted at edge T; y_valid high during the cycle after edge T+ORDER+1;
//   throughput one sample per ORDER+2 cycles.
//  x_ready = (state==IDLE) & ~commit_pend & ~clr_pend. x sampled into a register at accept.
//  Accumulator width PRECISION+COEF_WIDTH+AW+1; no overflow inside the MAC. Rounding = truncation.
//  coef_we: shadow write is accepted in any state, takes effect only through commit.
//  coef_commit: in IDLE -> copy at that edge. Otherwise set commit_pend, copy on the first IDLE cycle;
//   x_ready low that cycle. Active bank never changes mid-sample.
//  coef_commit and x_valid in the same IDLE cycle: commit wins, sample accepted next cycle with new coefs.
//  coef_we and coef_commit in the same cycle: the new write is included in the copy.
//  hist_clr: same deferral rule as commit (clr_pend). History zeroed; y output register unchanged.
//  rst mid-sample: sample is discarded and no y_valid is produced; everything returns to reset values.
// CONFIGURATION
//  IIR_FB_SCHED_SAT_EN defined: DONE saturates the result to [-2^(PRECISION-1), 2^(PRECISION-1)-1]
//   before it reaches y and history.
//  Not defined: two's-complement wrap (keep low PRECISION bits). History holds the same value as y.
// STRUCTURE
//  Shared package/header iir_pkg: FSM state encodings (IDLE, MAC, DONE), accumulator-width
//   localparam function, saturate function.
//  Sub-module iir_mac: registered signed multiply-accumulate (clr, en, a, b -> acc).
//   The FSM, banks and history stay in iir_fb_sched.
// TESTING (ORDER=2, COEF_FRAC=14 unless stated)
//  1 Reset: after rst, x_ready=1, y=0, y_valid=0. A sample at edge T gives y_valid exactly at T+3 cycles.
//  2 Impulse: b1=8192 (0.5), b2=0, commit; x=1000 then zeros -> y=1000,500,250,125,62.
//  3 Commit mid-sample: during MAC write b1=16384 and pulse commit -> current y uses old b1.
//    Next y uses the new b1. x_ready stays low one extra cycle.
//  4 Saturation: b1=24576 (1.5), x=30000 constant -> SAT_EN: y clamps at 32767.
//    Without SAT_EN: second y = 30000+45000 wrapped = 9464.
//  5 hist_clr after a step response -> next y equals x exactly; y unchanged until then.
//  6 rst asserted during MAC -> no y_valid. With x_valid held high, the first accept is 1 cycle after rst drops.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared definitions for the IIR feedback sequencer: FSM states, accumulator sizing
// and the output saturation helper.
package iir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int acc_width(input int prec, input int coef_w, input int aw);
        return prec + coef_w + aw + 1;
    endfunction

    // Clamp a wide signed value to the range of a prec-bit two's-complement number.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int prec);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (prec - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/iir_mac.sv
// Registered signed multiply-accumulate: clear has priority over accumulate.
module iir_mac #(
    parameter int A_W   = 16,
    parameter int B_W   = 16,
    parameter int ACC_W = 34
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clr,
    input  logic                    i_en,
    input  logic signed [A_W-1:0]   i_a,
    input  logic signed [B_W-1:0]   i_b,
    output logic signed [ACC_W-1:0] o_acc
);

    logic signed [A_W+B_W-1:0] w_prod;
    logic signed [ACC_W-1:0]   r_acc;

    assign w_prod = i_a * i_b;

    always_ff @(posedge clk) begin
        if (rst || i_clr)
            r_acc <= '0;
        else if (i_en)
            r_acc <= r_acc + ACC_W'(w_prod);
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/iir_fb_sched.sv
// Feedback sequencer for the IIR filter: one shared MAC over ORDER taps per sample,
// shadow/active coefficient banks and output history. Optional macro: IIR_FB_SCHED_SAT_EN.
module iir_fb_sched
    import iir_pkg::*;
#(
    parameter int   PRECISION  = 16,
    parameter int   COEF_WIDTH = 16,
    parameter int   COEF_FRAC  = 14,
    parameter int   ORDER      = 4,
    localparam int  AW         = (ORDER > 1) ? $clog2(ORDER) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         x_valid,
    output logic                         x_ready,
    input  logic signed [PRECISION-1:0]  x,
    output logic                         y_valid,
    output logic signed [PRECISION-1:0]  y,
    output logic                         busy,
    input  logic                         coef_we,
    input  logic [AW-1:0]                coef_addr,
    input  logic signed [COEF_WIDTH-1:0] coef_data,
    input  logic                         coef_commit,
    input  logic                         hist_clr
);

    localparam int ACC_W = acc_width(PRECISION, COEF_WIDTH, AW);

    state_t                       r_state;
    logic [AW-1:0]                r_cnt;
    logic signed [PRECISION-1:0]  r_x;
    logic signed [PRECISION-1:0]  r_y;
    logic                         r_y_valid;
    logic                         r_commit_pend;
    logic                         r_clr_pend;
    logic signed [COEF_WIDTH-1:0] r_shd [ORDER];
    logic signed [COEF_WIDTH-1:0] r_act [ORDER];
    logic signed [PRECISION-1:0]  r_hist [ORDER];

    logic signed [COEF_WIDTH-1:0] w_shd_next [ORDER];
    logic signed [ACC_W-1:0]      w_acc;
    logic signed [ACC_W-1:0]      w_total;
    logic signed [ACC_W-1:0]      w_scaled;
    logic signed [PRECISION-1:0]  w_y;
    logic                         w_idle;
    logic                         w_accept;
    logic                         w_do_commit;
    logic                         w_do_clr;
    logic                         w_coef_hit;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_do_commit = w_idle & (coef_commit | r_commit_pend);
    assign w_do_clr    = w_idle & (hist_clr | r_clr_pend);
    // A commit or clear arriving in IDLE takes that edge, so the sample waits a cycle.
    assign x_ready     = w_idle & ~r_commit_pend & ~r_clr_pend & ~coef_commit & ~hist_clr;
    assign w_accept    = x_valid & x_ready;
    assign w_coef_hit  = int'(coef_addr) < ORDER;

    always_comb begin
        for (int k = 0; k < ORDER; k++)
            w_shd_next[k] = r_shd[k];
        if (coef_we && w_coef_hit)
            w_shd_next[coef_addr] = coef_data;
    end

    iir_mac #(
        .A_W   (COEF_WIDTH),
        .B_W   (PRECISION),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_accept),
        .i_en  (r_state == ST_MAC),
        .i_a   (r_act[r_cnt]),
        .i_b   (r_hist[r_cnt]),
        .o_acc (w_acc)
    );

    assign w_total  = (ACC_W'(r_x) <<< COEF_FRAC) + w_acc;
    assign w_scaled = w_total >>> COEF_FRAC;
`ifdef IIR_FB_SCHED_SAT_EN
    assign w_y = PRECISION'(saturate(64'(w_scaled), PRECISION));
`else
    assign w_y = PRECISION'(w_scaled);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_y_valid     <= 1'b0;
            r_commit_pend <= 1'b0;
            r_clr_pend    <= 1'b0;
            for (int k = 0; k < ORDER; k++) begin
                r_shd[k]  <= '0;
                r_act[k]  <= '0;
                r_hist[k] <= '0;
            end
        end else begin
            r_y_valid <= 1'b0;
            for (int k = 0; k < ORDER; k++)
                r_shd[k] <= w_shd_next[k];

            if (coef_commit && !w_idle)
                r_commit_pend <= 1'b1;
            else if (w_do_commit)
                r_commit_pend <= 1'b0;
            if (hist_clr && !w_idle)
                r_clr_pend <= 1'b1;
            else if (w_do_clr)
                r_clr_pend <= 1'b0;

            if (w_do_commit)
                for (int k = 0; k < ORDER; k++)
                    r_act[k] <= w_shd_next[k];

            case (r_state)
                ST_IDLE: begin
                    if (w_do_clr)
                        for (int k = 0; k < ORDER; k++)
                            r_hist[k] <= '0;
                    if (w_accept) begin
                        r_x     <= x;
                        r_cnt   <= '0;
                        r_state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (r_cnt == AW'(ORDER - 1))
                        r_state <= ST_DONE;
                    else
                        r_cnt <= r_cnt + AW'(1);
                end
                ST_DONE: begin
                    r_y       <= w_y;
                    r_y_valid <= 1'b1;
                    for (int k = ORDER - 1; k > 0; k--)
                        r_hist[k] <= r_hist[k-1];
                    r_hist[0] <= w_y;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign y       = r_y;
    assign y_valid = r_y_valid;
    assign busy    = ~w_idle;

endmodule
